// File: rtl/spi_bridge_pkg.sv
// Shared types and constants for the SPI bridge datapath.
package spi_bridge_pkg;

  localparam int SPI_BYTE_W = 8;
  localparam int BIT_CNT_W  = $clog2(SPI_BYTE_W);

  // Mode 0: SCK idles low, MOSI launched on the falling edge, MISO sampled on the rising edge.
  localparam logic SCK_IDLE = 1'b0;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD
  } state_t;

endpackage

// File: rtl/spi_clkgen.sv
// SCK divider: one tick every CLKDIV enabled cycles; while running, ticks alternate rise/fall.
module spi_clkgen #(
  parameter int CLKDIV = 2
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_en,
  input  logic i_run,
  output logic o_tick,
  output logic o_rise,
  output logic o_fall
);

  localparam int CNT_W = $clog2(CLKDIV + 1);

  logic [CNT_W-1:0] cnt;
  logic             phase;

  assign o_tick = i_en && (cnt == CNT_W'(CLKDIV - 1));
  assign o_rise = o_tick && i_run && !phase;
  assign o_fall = o_tick && i_run && phase;

  always_ff @(posedge i_clk) begin
    if (i_reset || !i_en) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else begin
      cnt <= o_tick ? '0 : cnt + 1'b1;
      // Phase only advances while SCK is actually toggling, so every byte starts on a low half.
      if (!i_run) phase <= 1'b0;
      else if (o_tick) phase <= !phase;
    end
  end

endmodule

// File: rtl/spi_fifo_drain.sv
// SPI mode-0 master draining a first-word-fall-through byte FIFO; back-to-back bytes
// share one chip-select burst and each received byte is returned with a 1-cycle strobe.
module spi_fifo_drain
  import spi_bridge_pkg::*;
#(
  parameter int CLKDIV = 2,
  parameter int CS_GAP = 2
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_fifo_empty,
  input  logic [SPI_BYTE_W-1:0] i_fifo_data,
  output logic                  o_fifo_rd,
  output logic                  o_sck,
  output logic                  o_mosi,
  input  logic                  i_miso,
  output logic                  o_cs_n,
  output logic                  o_rx_valid,
  output logic [SPI_BYTE_W-1:0] o_rx_data,
  output logic                  o_busy
);

  localparam int                   GAP_W   = $clog2(CS_GAP + 1);
  localparam logic [BIT_CNT_W-1:0] BIT_MAX = BIT_CNT_W'(SPI_BYTE_W - 1);

  state_t                state;
  logic [SPI_BYTE_W-2:0] shreg;  // bits still to send after the one on MOSI
  logic [SPI_BYTE_W-1:0] rxreg;
  logic [BIT_CNT_W-1:0]  bit_cnt;
  logic [GAP_W-1:0]      gap_cnt;
  logic                  tick, rise, fall;

  spi_clkgen #(.CLKDIV(CLKDIV)) u_clkgen (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_en    (state != IDLE),
    .i_run   (state == SHIFT),
    .o_tick  (tick),
    .o_rise  (rise),
    .o_fall  (fall)
  );

  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every branch below
    // sees the register values from before this edge regardless of statement order.
    if (i_reset) begin
      state      <= IDLE;
      shreg      <= '0;
      rxreg      <= '0;
      bit_cnt    <= BIT_MAX;
      gap_cnt    <= '0;
      o_fifo_rd  <= 1'b0;
      o_sck      <= SCK_IDLE;
      o_mosi     <= 1'b0;
      o_cs_n     <= 1'b1;
      o_rx_valid <= 1'b0;
      o_rx_data  <= '0;
      o_busy     <= 1'b0;
    end else begin
      o_fifo_rd  <= 1'b0;
      o_rx_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (gap_cnt > GAP_W'(1)) begin
            gap_cnt <= gap_cnt - 1'b1;
          end else if (!i_fifo_empty) begin
            o_fifo_rd <= 1'b1;
            shreg     <= i_fifo_data[SPI_BYTE_W-2:0];
            o_mosi    <= i_fifo_data[SPI_BYTE_W-1];
            bit_cnt   <= BIT_MAX;
            o_cs_n    <= 1'b0;
            o_busy    <= 1'b1;
            state     <= SETUP;
          end
        end
        SETUP: if (tick) state <= SHIFT;
        SHIFT: begin
          if (rise) begin
            o_sck <= ~SCK_IDLE;
            rxreg <= {rxreg[SPI_BYTE_W-2:0], i_miso};
          end else if (fall) begin
            o_sck <= SCK_IDLE;
            if (bit_cnt != '0) begin
              bit_cnt <= bit_cnt - 1'b1;
              o_mosi  <= shreg[SPI_BYTE_W-2];
              shreg   <= {shreg[SPI_BYTE_W-3:0], 1'b0};
            end else begin
              o_rx_valid <= 1'b1;
              o_rx_data  <= rxreg;
              // Only this cycle's empty flag decides whether the burst continues.
              if (!i_fifo_empty) begin
                o_fifo_rd <= 1'b1;
                shreg     <= i_fifo_data[SPI_BYTE_W-2:0];
                o_mosi    <= i_fifo_data[SPI_BYTE_W-1];
                bit_cnt   <= BIT_MAX;
              end else begin
                state <= HOLD;
              end
            end
          end
        end
        HOLD: begin
          if (tick) begin
            o_cs_n  <= 1'b1;
            o_busy  <= 1'b0;
            o_mosi  <= 1'b0;
            gap_cnt <= GAP_W'(CS_GAP);
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
